// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that serialises strobe/ready requests from several
// masters onto a single memory port, with separate write/read data buses
// and a per-access timeout that turns a hung memory into an error response.
module mem_bus_arbiter #(
  parameter int ADDRESS_SIZE = 15,
  parameter int DATA_SIZE    = 32,
  parameter int CHANNELS     = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [CHANNELS-1:0]                chStrobe,
  input  logic [CHANNELS-1:0]                chWriteEnable,
  input  logic [CHANNELS*ADDRESS_SIZE-1:0]   chAddress,
  input  logic [CHANNELS*DATA_SIZE-1:0]      chWriteData,
  output logic [DATA_SIZE-1:0]               chReadData,
  output logic [CHANNELS-1:0]                chReady,
  output logic [CHANNELS-1:0]                chError,
  output logic [ADDRESS_SIZE-1:0]            memAddress,
  output logic                               memStrobe,
  output logic                               memWriteEnable,
  output logic [DATA_SIZE-1:0]               memWriteData,
  input  logic [DATA_SIZE-1:0]               memReadData,
  input  logic                               memReady,
  output logic [$clog2(CHANNELS)-1:0]        grant,
  output logic                               busy
);

  localparam int GW = $clog2(CHANNELS);
  // Counter is at least 8 bits so small TIMEOUT values keep a sane width.
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic [GW-1:0] LAST_CH = GW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDRESS_SIZE-1:0] mem_address_q, mem_address_d;
  logic [DATA_SIZE-1:0]    mem_write_data_q, mem_write_data_d;
  logic                    mem_write_enable_q, mem_write_enable_d;
  logic                    mem_strobe_q, mem_strobe_d;
  logic                    busy_q, busy_d;
  logic [DATA_SIZE-1:0]    ch_read_data_q, ch_read_data_d;
  logic [CHANNELS-1:0]     ch_ready_q, ch_ready_d;
  logic [CHANNELS-1:0]     ch_error_q, ch_error_d;

  logic [GW-1:0]           pick_s;
  logic                    pick_valid_s;
  logic [GW:0]             rr_sum_s;

  // One-hot decode of a channel index.
  function automatic logic [CHANNELS-1:0] grant_onehot(input logic [GW-1:0] g);
    return {{(CHANNELS-1){1'b0}}, 1'b1} << g;
  endfunction

  // Round-robin pick: first requester scanning from last_grant+1, wrapping.
  always_comb begin
    pick_s       = {GW{1'b0}};
    pick_valid_s = 1'b0;
    rr_sum_s     = {(GW+1){1'b0}};
    for (int i = 1; i <= CHANNELS; i++) begin
      rr_sum_s = {1'b0, last_grant_q} + (GW+1)'(i);
      if (rr_sum_s >= (GW+1)'(CHANNELS)) begin
        rr_sum_s = rr_sum_s - (GW+1)'(CHANNELS);
      end else begin
        rr_sum_s = rr_sum_s;
      end
      if (!pick_valid_s && chStrobe[rr_sum_s[GW-1:0]]) begin
        pick_s       = rr_sum_s[GW-1:0];
        pick_valid_s = 1'b1;
      end else begin
        pick_s       = pick_s;
      end
    end
  end

  // Next-state and registered-output computation for IDLE/ACCESS/DONE.
  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    last_grant_d       = last_grant_q;
    cnt_d              = cnt_q;
    mem_address_d      = mem_address_q;
    mem_write_data_d   = mem_write_data_q;
    mem_write_enable_d = mem_write_enable_q;
    mem_strobe_d       = 1'b0;
    busy_d             = 1'b0;
    ch_read_data_d     = ch_read_data_q;
    ch_ready_d         = {CHANNELS{1'b0}};
    ch_error_d         = {CHANNELS{1'b0}};
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d            = ACCESS;
          grant_d            = pick_s;
          last_grant_d       = pick_s;
          cnt_d              = {CW{1'b0}};
          mem_address_d      = chAddress[pick_s*ADDRESS_SIZE +: ADDRESS_SIZE];
          mem_write_data_d   = chWriteData[pick_s*DATA_SIZE +: DATA_SIZE];
          mem_write_enable_d = chWriteEnable[pick_s];
          mem_strobe_d       = 1'b1;
          busy_d             = 1'b1;
        end else begin
          state_d            = IDLE;
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (memReady) begin
          state_d        = DONE;
          ch_read_data_d = memReadData;
          ch_ready_d     = grant_onehot(grant_q);
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          // Hung memory: complete with zero data and an error flag.
          state_d        = DONE;
          ch_read_data_d = {DATA_SIZE{1'b0}};
          ch_ready_d     = grant_onehot(grant_q);
          ch_error_d     = grant_onehot(grant_q);
        end else begin
          cnt_d          = cnt_q + CW'(1);
          mem_strobe_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      grant_q            <= {GW{1'b0}};
      last_grant_q       <= LAST_CH;
      cnt_q              <= {CW{1'b0}};
      mem_address_q      <= {ADDRESS_SIZE{1'b0}};
      mem_write_data_q   <= {DATA_SIZE{1'b0}};
      mem_write_enable_q <= 1'b0;
      mem_strobe_q       <= 1'b0;
      busy_q             <= 1'b0;
      ch_read_data_q     <= {DATA_SIZE{1'b0}};
      ch_ready_q         <= {CHANNELS{1'b0}};
      ch_error_q         <= {CHANNELS{1'b0}};
    end else begin
      state_q            <= state_d;
      grant_q            <= grant_d;
      last_grant_q       <= last_grant_d;
      cnt_q              <= cnt_d;
      mem_address_q      <= mem_address_d;
      mem_write_data_q   <= mem_write_data_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_strobe_q       <= mem_strobe_d;
      busy_q             <= busy_d;
      ch_read_data_q     <= ch_read_data_d;
      ch_ready_q         <= ch_ready_d;
      ch_error_q         <= ch_error_d;
    end
  end

  assign chReadData     = ch_read_data_q;
  assign chReady        = ch_ready_q;
  assign chError        = ch_error_q;
  assign memAddress     = mem_address_q;
  assign memStrobe      = mem_strobe_q;
  assign memWriteEnable = mem_write_enable_q;
  assign memWriteData   = mem_write_data_q;
  assign grant          = grant_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a small memory model answers the
// memory port, expected completions are queued when requests are driven
// and compared when chReady pulses.
module tb_mem_bus_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int CH = 2;
  localparam int TO = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     chStrobe = '0;
  logic [CH-1:0]     chWriteEnable = '0;
  logic [CH*AW-1:0]  chAddress = '0;
  logic [CH*DW-1:0]  chWriteData = '0;
  logic [DW-1:0]     chReadData;
  logic [CH-1:0]     chReady;
  logic [CH-1:0]     chError;
  logic [AW-1:0]     memAddress;
  logic              memStrobe;
  logic              memWriteEnable;
  logic [DW-1:0]     memWriteData;
  logic [DW-1:0]     memReadData = '0;
  logic              memReady = 1'b0;
  logic [0:0]        grant;
  logic              busy;

  mem_bus_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .CHANNELS(CH), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .chStrobe(chStrobe), .chWriteEnable(chWriteEnable),
    .chAddress(chAddress), .chWriteData(chWriteData), .chReadData(chReadData),
    .chReady(chReady), .chError(chError), .memAddress(memAddress), .memStrobe(memStrobe),
    .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .memReadData(memReadData),
    .memReady(memReady), .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         ch;
    logic [DW-1:0] data;
    logic       err;
    logic       chk_data;
  } exp_t;
  exp_t sb[$];

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] last_rd_exp = '0;

  function automatic logic [DW-1:0] mem_val(input int a);
    if (model_mem.exists(a)) return model_mem[a];
    else return 32'hC0DE_0000 ^ 32'(a);
  endfunction

  // Memory model: answers mem_delay cycles into the access (-1 = never).
  int   mem_delay = 0;
  int   strobe_cnt = 0;
  logic ready_inject = 1'b0;
  always @(negedge clock) begin
    if (memStrobe) begin
      if (mem_delay >= 0 && strobe_cnt == mem_delay) begin
        memReady    = 1'b1;
        memReadData = mem_val(int'(memAddress));
        if (memWriteEnable) model_mem[int'(memAddress)] = memWriteData;
      end else begin
        memReady    = 1'b0;
        memReadData = 32'hBAD0_BAD0;
      end
      strobe_cnt++;
    end else begin
      memReady    = ready_inject;
      memReadData = 32'h0BAD_F00D;
      strobe_cnt  = 0;
    end
  end

  // Scoreboard monitor: pops one expectation per chReady pulse.
  exp_t          mon_e;
  logic [CH-1:0] mon_rdy;
  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if ((chError & ~chReady) !== '0) begin
        errors++;
        $display("FAIL sb_error_without_ready: chError=%b chReady=%b", chError, chReady);
      end
      if (chReady !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_ready: chReady=%b with nothing outstanding", chReady);
        end else begin
          mon_e   = sb.pop_front();
          mon_rdy = CH'(1) << mon_e.ch;
          if (chReady !== mon_rdy) begin
            errors++;
            $display("FAIL sb_ready: got %b want %b", chReady, mon_rdy);
          end
          checks++;
          if (chError !== (mon_e.err ? mon_rdy : '0)) begin
            errors++;
            $display("FAIL sb_error: got %b want err=%b on ch%0d", chError, mon_e.err, mon_e.ch);
          end
          if (mon_e.chk_data) begin
            checks++;
            if (chReadData !== mon_e.data) begin
              errors++;
              $display("FAIL sb_read_data: got %h want %h", chReadData, mon_e.data);
            end
            last_rd_exp = mon_e.data;
          end
        end
      end
    end
  end

  task automatic request(input int ch, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chStrobe[ch]          = 1'b1;
    chWriteEnable[ch]     = we;
    chAddress[ch*AW +: AW] = a;
    chWriteData[ch*DW +: DW] = d;
  endtask

  // Drives masters until all expectations drain; masters drop strobe on chReady.
  task automatic run_until_idle(input int budget, output logic timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (chStrobe != '0 || sb.size() != 0) begin
      @(negedge clock);
      chStrobe = chStrobe & ~chReady;
      n++;
      if (n > budget) begin
        timed_out = 1'b1;
        chStrobe = '0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({memStrobe, memWriteEnable, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {memStrobe, memWriteEnable, busy});
    end
    checks++;
    if ({chReady, chError} !== '0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", {chReady, chError});
    end
    checks++;
    if (memAddress !== '0 || memWriteData !== '0 || chReadData !== '0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0", memAddress, memWriteData, chReadData);
    end
    checks++;
    if (grant !== 1'b0) begin
      errors++; $display("FAIL reset_grant: got %0d want 0", grant);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (memStrobe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: strobe=%b busy=%b want 0 0", memStrobe, busy);
    end
  endtask

  task automatic test_single_read();
    int c0, rc;
    logic got;
    model_mem[32'h1234] = 32'hDEAD_BEEF;
    mem_delay = 1;
    @(negedge clock);
    c0 = cyc;
    request(0, 1'b0, 15'h1234, 32'h1111_1111);
    sb.push_back('{0, 32'hDEAD_BEEF, 1'b0, 1'b1});
    @(negedge clock);
    checks++;
    if (memStrobe !== 1'b1 || memAddress !== 15'h1234 || memWriteEnable !== 1'b0 || grant !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL read_access: strobe=%b addr=%h we=%b grant=%0d busy=%b want 1 1234 0 0 1",
                         memStrobe, memAddress, memWriteEnable, grant, busy);
    end
    got = 1'b0; rc = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (chReady != '0) begin got = 1'b1; rc = cyc; chStrobe = '0; end
    end
    checks++;
    if (!got || rc - c0 != 3) begin
      errors++; $display("FAIL read_latency: got %0d cycles (seen=%b) want 3", rc - c0, got);
    end
    @(negedge clock);
    checks++;
    if (chReady !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL read_pulse_width: chReady=%b busy=%b want 00 0", chReady, busy);
    end
  endtask

  task automatic test_write();
    logic to;
    mem_delay = 2;
    @(negedge clock);
    request(1, 1'b1, 15'h7FFF, 32'hA5A5_A5A5);
    sb.push_back('{1, 32'h0, 1'b0, 1'b0});
    @(negedge clock);
    checks++;
    if (memWriteEnable !== 1'b1 || memAddress !== 15'h7FFF || memWriteData !== 32'hA5A5_A5A5 || grant !== 1'b1) begin
      errors++; $display("FAIL write_access: we=%b addr=%h data=%h grant=%0d want 1 7fff a5a5a5a5 1",
                         memWriteEnable, memAddress, memWriteData, grant);
    end
    // Inputs change mid-access; the latched values must hold.
    chAddress[AW +: AW] = 15'h0000;
    chWriteData[DW +: DW] = 32'h0;
    @(negedge clock);
    checks++;
    if (memAddress !== 15'h7FFF || memWriteData !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL write_latched: addr=%h data=%h want 7fff a5a5a5a5", memAddress, memWriteData);
    end
    chStrobe = chStrobe & ~chReady;
    run_until_idle(20, to);
    checks++;
    if (to) begin errors++; $display("FAIL write_complete: timed out, want completion"); end
    // Read back through channel 0.
    mem_delay = 0;
    @(negedge clock);
    request(0, 1'b0, 15'h7FFF, 32'h0);
    sb.push_back('{0, 32'hA5A5_A5A5, 1'b0, 1'b1});
    run_until_idle(20, to);
    checks++;
    if (to) begin errors++; $display("FAIL readback_complete: timed out, want completion"); end
  endtask

  task automatic test_back_to_back();
    int c0, n;
    int rc[4];
    logic to;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    sb.delete();
    mem_delay = 0;
    @(negedge clock);
    c0 = cyc;
    request(0, 1'b0, 15'h0100, 32'h0);
    request(1, 1'b0, 15'h0200, 32'h0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{0, mem_val(32'h0100), 1'b0, 1'b1});
      sb.push_back('{1, mem_val(32'h0200), 1'b0, 1'b1});
    end
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clock);
      if (chReady != '0) begin
        rc[n] = cyc;
        n++;
        if (n == 4) chStrobe = '0;
      end
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL b2b_count: got %0d completions want 4", n);
    end else begin
      checks++;
      if (rc[0] - c0 != 2) begin
        errors++; $display("FAIL b2b_first_latency: got %0d want 2", rc[0] - c0);
      end
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (rc[j] - rc[j-1] != 3) begin
          errors++; $display("FAIL b2b_spacing: pulse %0d got %0d cycles want 3", j, rc[j] - rc[j-1]);
        end
      end
    end
    chStrobe = '0;
    run_until_idle(10, to);
  endtask

  task automatic test_timeout();
    int delays[3];
    int c0, rc, sc;
    logic got, e;
    delays = '{3, 4, -1};
    for (int k = 0; k < 3; k++) begin
      mem_delay = delays[k];
      e = (delays[k] < 0 || delays[k] >= TO);
      @(negedge clock);
      @(negedge clock);
      c0 = cyc;
      request(0, 1'b0, 15'h0042, 32'h0);
      sb.push_back('{0, e ? 32'h0 : mem_val(32'h0042), e, 1'b1});
      got = 1'b0; rc = 0; sc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clock);
        if (memStrobe) sc++;
        if (chReady != '0) begin got = 1'b1; rc = cyc; chStrobe = '0; end
      end
      checks++;
      if (!got || sc != TO || rc - c0 != TO + 1) begin
        errors++; $display("FAIL timeout_delay%0d: strobe_cycles=%0d ready_at=%0d seen=%b want %0d %0d",
                           delays[k], sc, rc - c0, got, TO, TO + 1);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic got, to;
    mem_delay = -1;
    @(negedge clock);
    @(negedge clock);
    request(1, 1'b0, 15'h0033, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (memStrobe) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL midreset_start: memStrobe never rose"); end
    reset = 1'b0;
    #1;
    checks++;
    if (memStrobe !== 1'b0 || grant !== 1'b0 || busy !== 1'b0 || chReady !== '0) begin
      errors++; $display("FAIL midreset_outputs: strobe=%b grant=%0d busy=%b ready=%b want 0 0 0 00",
                         memStrobe, grant, busy, chReady);
    end
    chStrobe = '0;
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    mem_delay = 1;
    @(negedge clock);
    request(1, 1'b0, 15'h0022, 32'h0);
    request(0, 1'b0, 15'h0011, 32'h0);
    sb.push_back('{0, mem_val(32'h0011), 1'b0, 1'b1});
    sb.push_back('{1, mem_val(32'h0022), 1'b0, 1'b1});
    @(negedge clock);
    checks++;
    if (grant !== 1'b0 || memAddress !== 15'h0011) begin
      errors++; $display("FAIL midreset_first_grant: grant=%0d addr=%h want 0 0011", grant, memAddress);
    end
    run_until_idle(30, to);
    checks++;
    if (to) begin errors++; $display("FAIL midreset_complete: timed out, want completion"); end
  endtask

  task automatic test_ready_in_idle();
    @(negedge clock);
    @(negedge clock);
    ready_inject = 1'b1;
    repeat (2) @(negedge clock);
    ready_inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (memStrobe !== 1'b0 || busy !== 1'b0 || chReady !== '0 || chReadData !== last_rd_exp) begin
        errors++; $display("FAIL idle_ready: strobe=%b busy=%b ready=%b rdata=%h want 0 0 00 %h",
                           memStrobe, busy, chReady, chReadData, last_rd_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    test_ready_in_idle();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d expectations never completed, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Multi-channel memory bus arbiter and bridge for the RISC-V simulation top level and the FPGA memory subsystem. It accepts strobe/ready requests from CHANNELS masters (core, debug loader, DMA) and serialises them onto one memory port using round-robin arbitration. It replaces the single bidirectional data line with separate write-data and read-data buses. A per-access timeout converts a hung memory into an error response instead of a core stall.

## Interface
Parameters:
- ADDRESS_SIZE, 15, address width in words.
- DATA_SIZE, 32, data width.
- CHANNELS, 2, number of masters; legal range 2..8.
- TIMEOUT, 255, maximum cycles waiting for memReady; 0 disables the timeout.

Ports (GW = $clog2(CHANNELS)):
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- chStrobe  in  CHANNELS  per-channel request.
- chWriteEnable  in  CHANNELS  per-channel write flag.
- chAddress  in  CHANNELS*ADDRESS_SIZE  packed addresses; channel i occupies bits [i*ADDRESS_SIZE +: ADDRESS_SIZE].
- chWriteData  in  CHANNELS*DATA_SIZE  packed write data.
- chReadData  out  DATA_SIZE  read data, shared by all channels, valid while that channel's chReady is high.
- chReady  out  CHANNELS  one-cycle completion pulse, one-hot.
- chError  out  CHANNELS  one-cycle timeout flag, coincident with chReady.
- memAddress  out  ADDRESS_SIZE  memory address.
- memStrobe  out  1  memory request.
- memWriteEnable  out  1  memory write flag.
- memWriteData  out  DATA_SIZE  memory write data.
- memReadData  in  DATA_SIZE  memory read data, sampled with memReady.
- memReady  in  1  memory completion.
- grant  out  GW  index of the channel currently owning the memory port.
- busy  out  1  high in states ACCESS and DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any chStrobe is high, select the first requesting channel in round-robin order, starting at lastGrant+1 and wrapping modulo CHANNELS.
  - Register that channel's address, write data and write enable onto the mem* outputs.
  - Set grant and lastGrant to the selected channel, clear the timeout counter, go to ACCESS.
  - If no channel requests, outputs hold their values and memStrobe stays 0.
- ACCESS:
  - memStrobe = 1; address, data and write enable are stable.
  - memReady sampled high: capture memReadData (write accesses also capture it, the value is don't-care), go to DONE, error flag 0.
  - Otherwise, if TIMEOUT != 0 and the counter equals TIMEOUT-1: capture 0 as read data, set the error flag, go to DONE.
  - Otherwise increment the counter. The counter is 8 bits wide or $clog2(TIMEOUT+1) bits, whichever is larger.
- DONE:
  - memStrobe = 0, chReady[grant] = 1, chError[grant] = error flag, chReadData = captured data.
  - Next state is always IDLE.
- Masters deassert chStrobe on the edge at which they sample chReady. A strobe that stays high is treated as a new request in the following IDLE cycle.
- Changing a master's chStrobe, address or data while its access is in progress has no effect; the inputs are latched in IDLE.
- memReady high outside ACCESS is ignored.
- chReadData holds its last value outside DONE.
- Reset (asynchronous, immediate, including mid-access):
  - State IDLE.
  - memStrobe, memWriteEnable, chReady, chError, busy = 0.
  - memAddress, memWriteData, chReadData = 0.
  - grant = 0, lastGrant = CHANNELS-1, so channel 0 wins the first arbitration.

## Timing
- Request high during cycle 0 → memStrobe high from cycle 1.
- memReady high in cycle k (k ≥ 1) → chReady high in cycle k+1.
- Minimum latency is 2 cycles, request to chReady. Back-to-back throughput is one access per 3 cycles: IDLE, ACCESS, DONE.
- Timeout: with memReady never asserted, chReady/chError are high in cycle TIMEOUT+1.
- Simultaneous requests: exactly one grant per IDLE cycle. A channel waiting while others request is served within CHANNELS accesses.

## Test plan
- Single read, ch0, address 0x1234, memReady one cycle after memStrobe, memReadData 0xDEADBEEF → chReady[0] one cycle, chReadData = 0xDEADBEEF, chError = 0.
- Write, ch1, address 0x7FFF, data 0xA5A5A5A5 → memWriteEnable = 1, memAddress = 0x7FFF, memWriteData = 0xA5A5A5A5 during ACCESS; chReady[1] pulses; chReady[0] stays 0.
- Both channels strobing continuously after reset → grants alternate 0,1,0,1 with chReady pulses spaced 3 cycles apart.
- TIMEOUT = 4, memReady held 0 → memStrobe high for exactly 4 cycles, then chReady[0] = chError[0] = 1, chReadData = 0.
- reset asserted low mid-ACCESS → memStrobe drops immediately, grant = 0, busy = 0. After reset releases, a ch1+ch0 request is granted to ch0 first.
- memReady pulsed in IDLE with no request → no chReady, state remains IDLE.
